// File: rtl/mux_src_sequencer_if.sv
// mux_src_sequencer_if: operand-load / select-control bus between a driver and the mux source sequencer.
// Signals:
//   din_i      [2:0]  operand data shared by both loads
//   load_x_i          level, X <= din_i each edge while high
//   load_y_i          level, Y <= din_i each edge while high
//   toggle_i          manual select request, rising edge acts
//   auto_en_i         level, 1 = automatic dwell alternation
//   x_o, y_o   [2:0]  registered operands to the mux
//   s_o               registered mux select
//   s_change_o        high in exactly the cycles where s_o holds a new value
// Modports: master drives requests, slave is the sequencer.
interface mux_src_sequencer_if;
    logic [2:0] din_i;
    logic       load_x_i;
    logic       load_y_i;
    logic       toggle_i;
    logic       auto_en_i;
    logic [2:0] x_o;
    logic [2:0] y_o;
    logic       s_o;
    logic       s_change_o;
    modport master (
        output din_i, load_x_i, load_y_i, toggle_i, auto_en_i,
        input  x_o, y_o, s_o, s_change_o
    );
    modport slave (
        input  din_i, load_x_i, load_y_i, toggle_i, auto_en_i,
        output x_o, y_o, s_o, s_change_o
    );
endinterface

// File: rtl/mux_src_sequencer.sv
// mux_src_sequencer: loads X/Y operands and drives the 2:1 mux select manually or by dwell-timed alternation.
// Ports:
//   clk    system clock, all state on rising edge
//   rst_n  asynchronous active-low reset
//   bus    mux_src_sequencer_if.slave (din/load/toggle/auto_en in; X/Y/s/s_change out)
// Parameters: DWELL (1..255) cycles s holds each value in AUTO; CNT_W counter width, 2^CNT_W >= DWELL.
// Build option: define MUX_SRC_SYNC_EN to pass toggle, auto_en, load_x, load_y through
// 2-flop synchronizers (adds 2 cycles to every input-to-effect latency; din stays unsynchronized).
module mux_src_sequencer #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_src_sequencer_if.slave  bus
);
    localparam logic [0:0] ST_MANUAL = 1'b0;
    localparam logic [0:0] ST_AUTO   = 1'b1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DWELL - 1);

    logic toggle, auto_en, load_x, load_y;

`ifdef MUX_SRC_SYNC_EN
    logic [1:0] tog_sync_q, auto_sync_q, lx_sync_q, ly_sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tog_sync_q  <= '0;
            auto_sync_q <= '0;
            lx_sync_q   <= '0;
            ly_sync_q   <= '0;
        end else begin
            tog_sync_q  <= {tog_sync_q[0], bus.toggle_i};
            auto_sync_q <= {auto_sync_q[0], bus.auto_en_i};
            lx_sync_q   <= {lx_sync_q[0], bus.load_x_i};
            ly_sync_q   <= {ly_sync_q[0], bus.load_y_i};
        end
    end
    assign toggle  = tog_sync_q[1];
    assign auto_en = auto_sync_q[1];
    assign load_x  = lx_sync_q[1];
    assign load_y  = ly_sync_q[1];
`else
    assign toggle  = bus.toggle_i;
    assign auto_en = bus.auto_en_i;
    assign load_x  = bus.load_x_i;
    assign load_y  = bus.load_y_i;
`endif

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       x_q, x_d, y_q, y_d;
    logic             s_q, s_d, chg_q, chg_d, tog_q, tog_rise;

    // tog_q tracks toggle in both states so a level held across an AUTO->MANUAL exit cannot fire late.
    assign tog_rise = toggle & ~tog_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        chg_d   = 1'b0;
        x_d     = load_x ? bus.din_i : x_q;
        y_d     = load_y ? bus.din_i : y_q;
        if (state_q == ST_MANUAL) begin
            // A toggle on the AUTO entry edge still flips; the dwell count starts from that edge.
            s_d   = s_q ^ tog_rise;
            chg_d = tog_rise;
            if (auto_en) begin
                state_d = ST_AUTO;
                cnt_d   = '0;
            end
        end else if (!auto_en) begin
            // Exit takes priority over a terminal count: s holds.
            state_d = ST_MANUAL;
            cnt_d   = '0;
        end else if (cnt_q == TERM) begin
            s_d   = ~s_q;
            chg_d = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_MANUAL;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            s_q     <= 1'b0;
            chg_q   <= 1'b0;
            tog_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            s_q     <= s_d;
            chg_q   <= chg_d;
            tog_q   <= toggle;
        end
    end

    assign bus.x_o        = x_q;
    assign bus.y_o        = y_q;
    assign bus.s_o        = s_q;
    assign bus.s_change_o = chg_q;
endmodule
